// File: rtl/mem_arbiter.sv
// Arbitrates one backend memory channel between instruction fetch (IF) and load/store (MEM).
// One transaction in flight; MEM wins unless its grant streak has starved a waiting IF.
module mem_arbiter #(
    parameter int MEM_STREAK_MAX = 4,
    parameter int TIMEOUT        = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce_if,
    input  logic [31:0] i_addr_if,
    output logic        o_stall_if,
    output logic [31:0] o_if_data,
    input  logic        i_mem_ce,
    input  logic        i_mem_we,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_write_data,
    input  logic [3:0]  i_mem_byte,
    output logic        o_stall_mem,
    output logic [31:0] o_mem_data,
    output logic        o_bk_req,
    output logic        o_bk_we,
    output logic [31:0] o_bk_addr,
    output logic [31:0] o_bk_wdata,
    output logic [3:0]  o_bk_byte,
    input  logic        i_bk_ack,
    input  logic [31:0] i_bk_rdata,
    output logic        o_err_timeout
);

    localparam int SW = $clog2(MEM_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MEM_STREAK_MAX);
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [15:0] TO_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_owner;
    logic        r_bk_req;
    logic        r_bk_we;
    logic [31:0] r_bk_addr;
    logic [31:0] r_bk_wdata;
    logic [3:0]  r_bk_byte;
    logic [31:0] r_if_data;
    logic [31:0] r_mem_data;
    logic [SW-1:0] r_streak;
    logic [15:0] r_timer;
    logic        r_err_timeout;

    logic        w_grant_mem;
    logic        w_grant_if;
    logic        w_done_ack;
    logic        w_done_to;
    logic [31:0] w_resp_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_mem = 1'b0;
        w_grant_if  = 1'b0;
        w_done_ack  = 1'b0;
        w_done_to   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_mem_ce && (!i_ce_if || r_streak < STREAK_MAX)) begin
                    w_grant_mem = 1'b1;
                    w_state_nxt = BUSY;
                end else if (i_ce_if) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (i_bk_ack) begin
                    w_done_ack  = 1'b1;
                    w_state_nxt = RESP;
                end else if (TO_EN && r_timer == TO_LAST) begin
                    w_done_to   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A timed-out transaction hands the core zero instead of stale data.
    assign w_resp_data = w_done_ack ? i_bk_rdata : 32'd0;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_owner       <= OWN_IF;
            r_bk_req      <= 1'b0;
            r_bk_we       <= 1'b0;
            r_bk_addr     <= 32'd0;
            r_bk_wdata    <= 32'd0;
            r_bk_byte     <= 4'd0;
            r_if_data     <= 32'd0;
            r_mem_data    <= 32'd0;
            r_streak      <= '0;
            r_timer       <= 16'd0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_grant_mem) begin
                r_owner    <= OWN_MEM;
                r_bk_req   <= 1'b1;
                r_bk_we    <= i_mem_we;
                r_bk_addr  <= i_mem_addr;
                r_bk_wdata <= i_mem_write_data;
                r_bk_byte  <= i_mem_byte;
            end else if (w_grant_if) begin
                r_owner    <= OWN_IF;
                r_bk_req   <= 1'b1;
                r_bk_we    <= 1'b0;
                r_bk_addr  <= i_addr_if;
                r_bk_wdata <= 32'd0;
                r_bk_byte  <= 4'b1111;
            end

            if (w_grant_mem || w_grant_if) r_timer <= 16'd0;
            else if (r_state == BUSY)      r_timer <= r_timer + 16'd1;

            if (w_done_ack || w_done_to) begin
                r_bk_req <= 1'b0;
                if (r_owner == OWN_MEM) r_mem_data <= w_resp_data;
                else                    r_if_data  <= w_resp_data;
            end
            if (w_done_to) r_err_timeout <= 1'b1;

            // Streak only grows while IF is actually being held off.
            if (w_grant_if) begin
                r_streak <= '0;
            end else if (w_grant_mem && i_ce_if) begin
                if (r_streak < STREAK_MAX) r_streak <= r_streak + SW'(1);
            end else if (r_state == IDLE && !i_ce_if) begin
                r_streak <= '0;
            end
        end
    end

    assign o_stall_if    = i_ce_if  & ~(r_state == RESP && r_owner == OWN_IF);
    assign o_stall_mem   = i_mem_ce & ~(r_state == RESP && r_owner == OWN_MEM);
    assign o_if_data     = r_if_data;
    assign o_mem_data    = r_mem_data;
    assign o_bk_req      = r_bk_req;
    assign o_bk_we       = r_bk_we;
    assign o_bk_addr     = r_bk_addr;
    assign o_bk_wdata    = r_bk_wdata;
    assign o_bk_byte     = r_bk_byte;
    assign o_err_timeout = r_err_timeout;

endmodule
